// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multicycle controller and the RV32I datapath.
// The controller is the master: it consumes the opcode and status flags and
// drives every select, write enable and handshake pulse.
interface multicycle_ctrl_fsm_if;
  logic [6:0] op;
  logic       zero;
  logic       cop_done;
  logic [1:0] ALUOp;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       AdrSrc;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       PCWrite;
  logic       CopStart;
  logic       CopTimeout;
  logic       IllegalOp;
  logic [3:0] state;

  modport master (
    input  op, zero, cop_done,
    output ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, RegWrite, MemWrite,
           PCWrite, CopStart, CopTimeout, IllegalOp, state
  );

  modport slave (
    output op, zero, cop_done,
    input  ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, RegWrite, MemWrite,
           PCWrite, CopStart, CopTimeout, IllegalOp, state
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Moore main controller for the multicycle RV32I datapath. Steps each
// instruction through fetch/decode/execute/memory/writeback and runs a
// start/done handshake, guarded by a timeout counter, with the GCD/LCM
// coprocessor for custom-0 instructions.
module multicycle_ctrl_fsm #(
  parameter int unsigned COP_TIMEOUT = 64
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWB    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StAluWB    = 4'd7,
    StExecuteI = 4'd8,
    StJal      = 4'd9,
    StBeq      = 4'd10,
    StCopStart = 4'd11,
    StCopWait  = 4'd12,
    StCopWB    = 4'd13
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBeq    = 7'b1100011;
  localparam logic [6:0] OpCustom = 7'b0001011;

  localparam int unsigned   CntW    = $clog2(COP_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(COP_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [1:0] alu_op, alu_src_a, alu_src_b, result_src;
  logic       adr_src, ir_write, reg_write, mem_write, pc_update, branch;
  logic       cop_start, cop_timeout, illegal_op;

  // State and coprocessor wait counter; reset drops straight back to Fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d = StFetch;
    cnt_d   = cnt_q;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (bus.op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecuteR;
          OpIType:         state_d = StExecuteI;
          OpJal:           state_d = StJal;
          OpBeq:           state_d = StBeq;
          OpCustom:        state_d = StCopStart;
          default:         state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = (bus.op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  state_d = StMemWB;
      StMemWB:    state_d = StFetch;
      StMemWrite: state_d = StFetch;
      StExecuteR: state_d = StAluWB;
      StExecuteI: state_d = StAluWB;
      StAluWB:    state_d = StFetch;
      StJal:      state_d = StAluWB;
      StBeq:      state_d = StFetch;
      StCopStart: begin
        cnt_d   = '0;
        state_d = StCopWait;
      end
      StCopWait: begin
        // A result arriving on the last allowed cycle still wins over timeout.
        if (bus.cop_done) begin
          state_d = StCopWB;
        end else if (cnt_q == CntLast) begin
          state_d = StFetch;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = StCopWait;
        end
      end
      StCopWB: state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  // Output decode of the current state (plus zero/cop_done/counter for pulses).
  always_comb begin
    alu_op      = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    pc_update   = 1'b0;
    branch      = 1'b0;
    cop_start   = 1'b0;
    cop_timeout = 1'b0;
    illegal_op  = 1'b0;
    case (state_q)
      StFetch: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          OpLoad, OpStore, OpRType, OpIType, OpJal, OpBeq, OpCustom: illegal_op = 1'b0;
          default: illegal_op = 1'b1;
        endcase
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      StMemRead: adr_src = 1'b1;
      StMemWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      StExecuteR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      StExecuteI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      StAluWB: reg_write = 1'b1;
      StJal: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      StBeq: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      StCopStart: cop_start = 1'b1;
      StCopWait:  cop_timeout = ~bus.cop_done & (cnt_q == CntLast);
      StCopWB: begin
        result_src = 2'b11;
        reg_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ALUOp      = alu_op;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.AdrSrc     = adr_src;
  assign bus.IRWrite    = ir_write;
  assign bus.RegWrite   = reg_write;
  assign bus.MemWrite   = mem_write;
  assign bus.PCWrite    = pc_update | (branch & bus.zero);
  assign bus.CopStart   = cop_start;
  assign bus.CopTimeout = cop_timeout;
  assign bus.IllegalOp  = illegal_op;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: per-cycle expected output vectors
// and input stimulus are queued, then replayed and compared cycle by cycle.
module tb_multicycle_ctrl_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] aluop;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] rs;
    logic       adr;
    logic       irw;
    logic       rw;
    logic       mw;
    logic       pcw;
    logic       cs;
    logic       ct;
    logic       ill;
  } vec_t;

  logic clk;
  logic reset;
  multicycle_ctrl_fsm_if bus ();

  multicycle_ctrl_fsm #(.COP_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  vec_t exp_q[$];
  logic [1:0] stim_q[$];

  function automatic vec_t mk(int st, int aluop, int sa, int sb, int rs, bit adr, bit irw,
                              bit rw, bit mw, bit pcw, bit cs, bit ct, bit ill);
    vec_t v;
    v.st = 4'(st); v.aluop = 2'(aluop); v.sa = 2'(sa); v.sb = 2'(sb); v.rs = 2'(rs);
    v.adr = adr; v.irw = irw; v.rw = rw; v.mw = mw; v.pcw = pcw;
    v.cs = cs; v.ct = ct; v.ill = ill;
    return v;
  endfunction

  function automatic vec_t observe();
    vec_t v;
    v.st = bus.state; v.aluop = bus.ALUOp; v.sa = bus.ALUSrcA; v.sb = bus.ALUSrcB;
    v.rs = bus.ResultSrc; v.adr = bus.AdrSrc; v.irw = bus.IRWrite; v.rw = bus.RegWrite;
    v.mw = bus.MemWrite; v.pcw = bus.PCWrite; v.cs = bus.CopStart; v.ct = bus.CopTimeout;
    v.ill = bus.IllegalOp;
    return v;
  endfunction

  // Expected per-state vectors, written from the state table.
  vec_t F, D, DILL, MA, MR, MWB, MW, ER, AWB, EI, J, BEQ1, BEQ0, CS, CW, CWT, CWB;

  task automatic check_vec(input string tag, input vec_t e);
    vec_t o;
    o = observe();
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic check_cnt(input string tag);
    n_checks++;
    assert (dut.cnt_q === '0) else begin
      n_fail++;
      $error("FAIL %s: observed counter %0d expected 0", tag, dut.cnt_q);
    end
  endtask

  task automatic push(input vec_t e, input bit z, input bit d);
    exp_q.push_back(e);
    stim_q.push_back({z, d});
  endtask

  // Replay queued stimulus; called just after a rising edge.
  task automatic drain(input string tag);
    int   idx;
    logic [1:0] s;
    vec_t e;
    idx = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      bus.zero     = s[1];
      bus.cop_done = s[0];
      @(negedge clk);
      e = exp_q.pop_front();
      check_vec($sformatf("%s[%0d]", tag, idx), e);
      @(posedge clk);
      #1;
      idx++;
    end
  endtask

  initial begin
    F    = mk(0, 0, 0, 2, 2, 0, 1, 0, 0, 1, 0, 0, 0);
    D    = mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    DILL = mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    MA   = mk(2, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    MR   = mk(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    MWB  = mk(4, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    MW   = mk(5, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    ER   = mk(6, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    AWB  = mk(7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    EI   = mk(8, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    J    = mk(9, 0, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    BEQ1 = mk(10, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    BEQ0 = mk(10, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    CS   = mk(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    CW   = mk(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    CWT  = mk(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    CWB  = mk(13, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0);

    bus.op = 7'b0; bus.zero = 1'b0; bus.cop_done = 1'b0;
    reset = 1'b1;
    #2;
    check_vec("reset", F);
    check_cnt("reset_cnt");
    @(posedge clk);
    #1;
    check_vec("reset_hold", F);
    reset = 1'b0;

    // lw: 5 cycles
    bus.op = 7'b0000011;
    push(F, 0, 0); push(D, 0, 0); push(MA, 0, 0); push(MR, 0, 0); push(MWB, 0, 0);
    drain("lw");
    // sw: 4 cycles
    bus.op = 7'b0100011;
    push(F, 0, 0); push(D, 0, 0); push(MA, 0, 0); push(MW, 0, 0);
    drain("sw");
    // R-type
    bus.op = 7'b0110011;
    push(F, 0, 0); push(D, 0, 0); push(ER, 0, 0); push(AWB, 0, 0);
    drain("rtype");
    // I-type
    bus.op = 7'b0010011;
    push(F, 0, 0); push(D, 0, 0); push(EI, 0, 0); push(AWB, 0, 0);
    drain("itype");
    // jal
    bus.op = 7'b1101111;
    push(F, 0, 0); push(D, 0, 0); push(J, 0, 0); push(AWB, 0, 0);
    drain("jal");
    // beq taken, then not taken
    bus.op = 7'b1100011;
    push(F, 0, 0); push(D, 0, 0); push(BEQ1, 1, 0);
    push(F, 0, 0); push(D, 1, 0); push(BEQ0, 0, 0);
    drain("beq");
    // illegal opcode
    bus.op = 7'b1111111;
    push(F, 0, 0); push(DILL, 0, 0);
    drain("illegal");
    // custom-0: early done ignored in CopStart, done on 3rd CopWait
    bus.op = 7'b0001011;
    push(F, 0, 0); push(D, 0, 0); push(CS, 0, 1);
    push(CW, 0, 0); push(CW, 0, 0); push(CW, 0, 1); push(CWB, 0, 0);
    drain("cop_done3");
    // custom-0 timeout after 4 CopWait cycles
    push(F, 0, 0); push(D, 0, 0); push(CS, 0, 0);
    push(CW, 0, 0); push(CW, 0, 0); push(CW, 0, 0); push(CWT, 0, 0);
    drain("cop_timeout");
    // custom-0: done on the 4th CopWait cycle beats the timeout
    push(F, 0, 0); push(D, 0, 0); push(CS, 0, 0);
    push(CW, 0, 0); push(CW, 0, 0); push(CW, 0, 0); push(CW, 0, 1); push(CWB, 0, 0);
    drain("cop_done4");
    // custom-0, reset asynchronously during CopWait
    push(F, 0, 0); push(D, 0, 0); push(CS, 0, 0); push(CW, 0, 0); push(CW, 0, 0);
    drain("cop_pre_rst");
    #1;
    reset = 1'b1;
    #1;
    check_vec("async_rst", F);
    check_cnt("async_rst_cnt");
    @(posedge clk);
    #1;
    check_vec("async_rst_hold", F);
    reset = 1'b0;
    // sw after reset, then a final Fetch
    bus.op = 7'b0100011;
    push(F, 0, 0); push(D, 0, 0); push(MA, 0, 0); push(MW, 0, 0); push(F, 0, 0);
    drain("sw_post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Moore-style main controller for the multicycle RV32I datapath of the GCD/LCM coprocessor core. It sequences each instruction through fetch, decode, execute, memory and writeback states and generates the datapath's mux selects and write enables. It generates the 2-bit ALUOp consumed by the downstream ALU decoder (ALUOp 00 = add, 01 = subtract, 10 = decode by funct3/funct7). It also runs a start/done handshake with the GCD/LCM coprocessor for custom-0 instructions, guarded by a timeout.

## Interface
- COP_TIMEOUT, 64, max CopWait cycles before abandoning a coprocessor op; legal range >= 1
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces state to Fetch immediately
- op  in  7  instruction opcode, Instr[6:0], from the instruction register
- zero  in  1  ALU zero flag
- cop_done  in  1  coprocessor result valid; sampled only in CopWait
- ALUOp  out  2  to ALU decoder
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 register
- ALUSrcB  out  2  00 rs2 register, 01 ImmExt, 10 constant 4
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 coprocessor result
- AdrSrc  out  1  0 PC, 1 Result
- IRWrite, RegWrite, MemWrite, PCWrite  out  1 each  write enables
- CopStart  out  1  one-cycle coprocessor start pulse
- CopTimeout  out  1  pulse: coprocessor op abandoned
- IllegalOp  out  1  pulse: unrecognised opcode in Decode
- state  out  4  current state encoding, for debug

## Operation
- State encoding: Fetch 0, Decode 1, MemAdr 2, MemRead 3, MemWB 4, MemWrite 5, ExecuteR 6, ALUWB 7, ExecuteI 8, JAL 9, BEQ 10, CopStart 11, CopWait 12, CopWB 13. Encodings 14 and 15 are unreachable and must go to Fetch.
- Outputs are a pure decode of state, plus zero, cop_done and the counter. Every output not listed for a state is 0.
- Fetch: IRWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next: Decode.
- Decode: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op:
  - 0000011 or 0100011 -> MemAdr
  - 0110011 -> ExecuteR
  - 0010011 -> ExecuteI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - 0001011 -> CopStart
  - any other op -> Fetch, with IllegalOp=1 this cycle
- MemAdr: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MemRead if op=0000011, else MemWrite.
- MemRead: ResultSrc=00, AdrSrc=1. Next: MemWB.
- MemWB: ResultSrc=01, RegWrite=1. Next: Fetch.
- MemWrite: ResultSrc=00, AdrSrc=1, MemWrite=1. Next: Fetch.
- ExecuteR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- ExecuteI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next: Fetch.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: Fetch.
- CopStart: CopStart=1, counter cleared to 0. Next: CopWait. cop_done is ignored in this state.
- CopWait:
  - cop_done=1 -> CopWB; done takes priority over timeout.
  - else if counter == COP_TIMEOUT-1 -> Fetch, with CopTimeout=1 this cycle; no writeback.
  - else counter increments; stay in CopWait.
- CopWB: ResultSrc=11, RegWrite=1. Next: Fetch.
- PCWrite = PCUpdate | (Branch & zero). PCUpdate and Branch are internal only.
- Counter width is $clog2(COP_TIMEOUT+1). It never wraps, because it is cleared in CopStart and saturates at the exit condition.

## Timing
- Reset: state=0 (Fetch) asynchronously, counter=0. While reset is high, outputs equal the Fetch decode: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10, all others 0. The datapath is held in reset concurrently.
- Reset asserted mid-operation (e.g. in CopWait or MemWrite): immediate return to Fetch. No CopStart, CopTimeout or write pulse is generated afterwards.
- Cycles per instruction, Fetch to next Fetch:
  - lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, illegal 2
  - custom-0: 5 + k, where cop_done first seen in the k-th CopWait cycle (k >= 0)
  - custom-0 timeout: 3 + COP_TIMEOUT
- CopStart is high for exactly one cycle per custom-0 instruction.
- CopTimeout and IllegalOp are single-cycle pulses, combinational from state and inputs.

## Test plan
- Reset, release, op=0000011 -> states 0,1,2,3,4,0. RegWrite=1 only in state 4, with ResultSrc=01. AdrSrc=1 in state 3.
- op=0110011 -> ALUOp sequence 00,00,10,00. RegWrite in state 7. Repeat with op=1100011: zero=1 gives PCWrite=1 in BEQ; zero=0 gives PCWrite=0.
- op=0001011, cop_done=1 already in the CopStart cycle (ignored), then low, then high on the 3rd CopWait cycle -> one CopStart pulse; CopWB then Fetch; ResultSrc=11 with RegWrite=1.
- COP_TIMEOUT=4, op=0001011, cop_done held 0 -> exactly 4 CopWait cycles; CopTimeout=1 on the 4th; next state Fetch; RegWrite never asserted.
- COP_TIMEOUT=4, cop_done=1 on the 4th CopWait cycle -> CopWB entered, CopTimeout stays 0.
- op=1111111 -> IllegalOp=1 in Decode, then Fetch. Separately, assert reset asynchronously mid-CopWait -> state=0 before the next clock edge; counter=0.
